// File: rtl/image_filter_3x3.sv
// 3x3 neighbourhood filter: bypass, Sobel-X, Sobel-Y or gradient magnitude.
// Two line buffers feed a sliding window; a fixed three-stage pipeline follows.
module image_filter_3x3 #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640,
    parameter int CNT_W  = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [CNT_W-1:0]  iX_Cont,
    input  logic [CNT_W-1:0]  iY_Cont,
    input  logic [1:0]        iMODE,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [1:0]        oMODE
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int GW = DATA_W + 3;

    logic [DATA_W-1:0] line0 [IMG_W];
    logic [DATA_W-1:0] line1 [IMG_W];

    logic [AW-1:0]     addr;
    logic              in_range;
    logic              frame_start;
    logic              border;
    logic [1:0]        mode_eff;
    logic [DATA_W-1:0] col_top;
    logic [DATA_W-1:0] col_mid;
    logic [DATA_W-1:0] col_bot;

    logic [2:0][2:0][DATA_W-1:0] win;
    logic                        s1_val;
    logic                        s1_zero;
    logic [1:0]                  s1_mode;

    logic [GW-1:0]     gx_c;
    logic [GW-1:0]     gy_c;
    logic [GW-1:0]     s2_gx;
    logic [GW-1:0]     s2_gy;
    logic [DATA_W-1:0] s2_centre;
    logic              s2_val;
    logic              s2_zero;
    logic [1:0]        s2_mode;

    logic [GW-1:0]     abs_x;
    logic [GW-1:0]     abs_y;
    logic [GW:0]       mag;
    logic [DATA_W-1:0] result;

    function automatic logic [GW-1:0] ext(input logic [DATA_W-1:0] v);
        return {3'b000, v};
    endfunction

    function automatic logic [GW-1:0] abs_of(input logic [GW-1:0] v);
        return v[GW-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic [GW:0] v);
        return (|v[GW:DATA_W]) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
    endfunction

    // Out-of-range columns contribute zeros and never touch the buffers
    always_comb begin
        addr        = iX_Cont[AW-1:0];
        in_range    = iX_Cont < CNT_W'(IMG_W);
        frame_start = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
        border      = (iX_Cont < CNT_W'(2)) || (iY_Cont < CNT_W'(2)) || !in_range;
        mode_eff    = frame_start ? iMODE : oMODE;
        col_top     = in_range ? line1[addr] : '0;
        col_mid     = in_range ? line0[addr] : '0;
        col_bot     = in_range ? iDATA : '0;
    end

    always_ff @(posedge iCLK) begin
        if (iDVAL && in_range) begin
            line1[addr] <= line0[addr];
            line0[addr] <= iDATA;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            win     <= '0;
            s1_val  <= 1'b0;
            s1_zero <= 1'b1;
            s1_mode <= 2'd0;
            oMODE   <= 2'd0;
        end else begin
            s1_val <= iDVAL;
            if (iDVAL) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= col_top;
                win[1][2] <= col_mid;
                win[2][2] <= col_bot;
                s1_zero   <= border;
                s1_mode   <= mode_eff;
            end
            if (frame_start) begin
                oMODE <= iMODE;
            end
        end
    end

    always_comb begin
        gx_c = (ext(win[0][2]) + (ext(win[1][2]) << 1) + ext(win[2][2]))
             - (ext(win[0][0]) + (ext(win[1][0]) << 1) + ext(win[2][0]));
        gy_c = (ext(win[2][0]) + (ext(win[2][1]) << 1) + ext(win[2][2]))
             - (ext(win[0][0]) + (ext(win[0][1]) << 1) + ext(win[0][2]));
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s2_gx     <= '0;
            s2_gy     <= '0;
            s2_centre <= '0;
            s2_val    <= 1'b0;
            s2_zero   <= 1'b1;
            s2_mode   <= 2'd0;
        end else begin
            s2_val <= s1_val;
            if (s1_val) begin
                s2_gx     <= gx_c;
                s2_gy     <= gy_c;
                s2_centre <= win[1][1];
                s2_zero   <= s1_zero;
                s2_mode   <= s1_mode;
            end
        end
    end

    always_comb begin
        abs_x = abs_of(s2_gx);
        abs_y = abs_of(s2_gy);
        mag   = {1'b0, abs_x} + {1'b0, abs_y};
        case (s2_mode)
            2'd0:    result = s2_centre;
            2'd1:    result = sat({1'b0, abs_x});
            2'd2:    result = sat({1'b0, abs_y});
            default: result = sat(mag);
        endcase
        if (s2_zero) begin
            result = '0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
        end else begin
            oDVAL <= s2_val;
            if (s2_val) begin
                oDATA <= result;
            end
        end
    end

endmodule
